// File: rtl/umi_pkg.sv
// Shared UMI definitions: default bus widths and command-field positions.
// Used by the request arbiter and any response-side arbiter built on the same picker.
package umi_pkg;

  // Default bus widths for a UMI link.
  localparam int UMI_AW = 64;
  localparam int UMI_CW = 32;
  localparam int UMI_DW = 256;

  // End-of-message flag position inside cmd; only consulted when message locking is built in.
  localparam int UMI_EOM_BIT = 22;

endpackage : umi_pkg

// File: rtl/umi_rr_select.sv
// Purely combinational N-way rotating-priority picker.
// Searches valid[] starting at ptr, wrapping N-1 -> 0; the first set bit wins.
// Produces a one-hot grant, the binary index of the winner and an any-valid flag.
module umi_rr_select #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx,
  output logic          any
);

  // One extra bit so ptr+offset never overflows before the modulo fold.
  localparam logic [PW:0] N_W = (PW+1)'(N);

  logic [PW:0] pos;

  // Walk the N positions in priority order; the first valid one is granted.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves a value unassigned (no latches).
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    pos   = '0;
    for (int k = 0; k < N; k++) begin
      pos = {1'b0, ptr} + (PW+1)'(k);
      if (pos >= N_W) pos = pos - N_W;
      if (!any && valid[pos[PW-1:0]]) begin
        any                = 1'b1;
        grant[pos[PW-1:0]] = 1'b1;
        idx                = pos[PW-1:0];
      end
    end
  end

endmodule : umi_rr_select

// File: rtl/umi_rr_arbiter.sv
// Round-robin merge of N UMI request streams into one registered UMI stream.
// The output register decouples the downstream FIFO write from the source-side mux;
// the only combinational ready path is accept = ~out_valid | out_ready.
// Optional message locking is compiled in with `define UMI_ARB_LOCK_EN: a stream
// that starts a multi-beat message (cmd[EOMBIT]=0) keeps the grant until its EOM beat.
module umi_rr_arbiter
  import umi_pkg::*;
#(
  parameter int N      = 4,
  parameter int AW     = UMI_AW,
  parameter int CW     = UMI_CW,
  parameter int DW     = UMI_DW,
  parameter int EOMBIT = UMI_EOM_BIT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    umi_in_valid,
  input  logic [N*CW-1:0] umi_in_cmd,
  input  logic [N*AW-1:0] umi_in_dstaddr,
  input  logic [N*AW-1:0] umi_in_srcaddr,
  input  logic [N*DW-1:0] umi_in_data,
  output logic [N-1:0]    umi_in_ready,
  output logic            umi_out_valid,
  output logic [CW-1:0]   umi_out_cmd,
  output logic [AW-1:0]   umi_out_dstaddr,
  output logic [AW-1:0]   umi_out_srcaddr,
  output logic [DW-1:0]   umi_out_data,
  input  logic            umi_out_ready
);

  localparam int          PW       = $clog2(N);
  localparam logic [PW-1:0] LAST_IDX = PW'(N-1);

`ifdef UMI_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  // Registered state.
  logic [PW-1:0] ptr_q,       ptr_d;
  logic          out_valid_q, out_valid_d;
  logic [CW-1:0] cmd_q,       cmd_d;
  logic [AW-1:0] dstaddr_q,   dstaddr_d;
  logic [AW-1:0] srcaddr_q,   srcaddr_d;
  logic [DW-1:0] data_q,      data_d;
  logic          lock_q,      lock_d;
  logic [PW-1:0] lock_idx_q,  lock_idx_d;

  // Arbitration signals.
  logic [N-1:0]  sel_valid;
  logic [N-1:0]  grant;
  logic [PW-1:0] win_idx;
  logic [PW-1:0] next_idx;
  logic          any_valid;
  logic          accept;
  logic          xfer;

  // Winner's payload.
  logic [CW-1:0] cmd_sel;
  logic [AW-1:0] dstaddr_sel;
  logic [AW-1:0] srcaddr_sel;
  logic [DW-1:0] data_sel;
  logic          sel_eom;

  // While a message is locked only the owning stream is visible to the picker.
  always_comb begin
    sel_valid = umi_in_valid;
    if (lock_q) begin
      sel_valid             = '0;
      sel_valid[lock_idx_q] = umi_in_valid[lock_idx_q];
    end
  end

  umi_rr_select #(
    .N  (N),
    .PW (PW)
  ) u_select (
    .valid (sel_valid),
    .ptr   (ptr_q),
    .grant (grant),
    .idx   (win_idx),
    .any   (any_valid)
  );

  // Output slot is free when empty or draining this cycle; ready is held low during reset.
  always_comb begin
    accept       = ~out_valid_q | umi_out_ready;
    xfer         = accept & any_valid & ~reset;
    umi_in_ready = grant & {N{accept & ~reset}};
    next_idx     = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
  end

  // Route the granted stream's payload to the output register inputs.
  always_comb begin
    cmd_sel     = '0;
    dstaddr_sel = '0;
    srcaddr_sel = '0;
    data_sel    = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        cmd_sel     = umi_in_cmd[i*CW +: CW];
        dstaddr_sel = umi_in_dstaddr[i*AW +: AW];
        srcaddr_sel = umi_in_srcaddr[i*AW +: AW];
        data_sel    = umi_in_data[i*DW +: DW];
      end
    end
    sel_eom = cmd_sel[EOMBIT];
  end

  // Next-state: load on transfer, clear valid when the slot frees with nothing to load.
  always_comb begin
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    cmd_d       = cmd_q;
    dstaddr_d   = dstaddr_q;
    srcaddr_d   = srcaddr_q;
    data_d      = data_q;
    lock_d      = lock_q;
    lock_idx_d  = lock_idx_q;
    if (accept) out_valid_d = any_valid;
    if (xfer) begin
      cmd_d     = cmd_sel;
      dstaddr_d = dstaddr_sel;
      srcaddr_d = srcaddr_sel;
      data_d    = data_sel;
      // A locked stream keeps ptr parked until its EOM beat moves it past the owner.
      if (!lock_q || sel_eom) ptr_d = next_idx;
      lock_d     = LOCK_EN & ~sel_eom;
      lock_idx_d = win_idx;
    end
  end

  // State registers with synchronous reset; a held output beat is discarded.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (reset) begin
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      cmd_q       <= '0;
      dstaddr_q   <= '0;
      srcaddr_q   <= '0;
      data_q      <= '0;
      lock_q      <= 1'b0;
      lock_idx_q  <= '0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      cmd_q       <= cmd_d;
      dstaddr_q   <= dstaddr_d;
      srcaddr_q   <= srcaddr_d;
      data_q      <= data_d;
      lock_q      <= lock_d;
      lock_idx_q  <= lock_idx_d;
    end
  end

  assign umi_out_valid   = out_valid_q;
  assign umi_out_cmd     = cmd_q;
  assign umi_out_dstaddr = dstaddr_q;
  assign umi_out_srcaddr = srcaddr_q;
  assign umi_out_data    = data_q;

endmodule : umi_rr_arbiter
